// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: DEPTH-entry FIFO of word-aligned store entries.
// Each entry is {word address, data word, byte mask}. Stores enter at any
// naturally aligned lane offset and drain to data memory over valid/ready.
// Loads are forwarded combinationally from the newest matching entry.
// Optional feature macro: LSU_SB_COALESCE_EN. When defined, a store to the
// youngest entry's word address merges into that entry.
// DATA_W must be at least 16 so that the lane offset field is non-empty.
module lsu_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [ADDR_W-1:0]         st_addr,
  input  logic [1:0]                st_size,
  input  logic [DATA_W-1:0]         st_data,
  output logic                      st_misalign,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [DATA_W/8-1:0]       mem_bmask,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [1:0]                ld_size,
  input  logic                      ld_unsigned,
  output logic                      ld_hit,
  output logic                      ld_partial,
  output logic [DATA_W-1:0]         ld_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int L  = DATA_W / 8;
  localparam int OB = $clog2(L);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [L-1:0]      mask_q [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          misalign_q;

  // Store decode
  logic [OB-1:0]     st_off;
  int                st_bytes;
  logic              st_bad;
  logic [L-1:0]      st_mask;
  logic [DATA_W-1:0] st_wdata;
  logic [ADDR_W-1:0] st_word;

  logic          accept, push_ok, pop, merge, alloc;
  logic [PW-1:0] youngest;

  // Decode store size/offset into lane mask, shifted data and word address
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    st_off   = st_addr[OB-1:0];
    st_bytes = 1 << st_size;
    st_bad   = (st_bytes > L) || ((int'(st_off) & (st_bytes - 1)) != 0);
    st_mask  = '0;
    for (int j = 0; j < L; j++) begin
      st_mask[j] = (j >= int'(st_off)) && (j < int'(st_off) + st_bytes);
    end
    st_wdata = st_data << {st_off, 3'b000};
    st_word  = {st_addr[ADDR_W-1:OB], {OB{1'b0}}};
  end

  assign st_ready  = (count_q != CW'(DEPTH));
  assign mem_valid = (count_q != '0);
  assign accept    = st_valid && st_ready;
  assign push_ok   = accept && !st_bad;
  assign pop       = mem_valid && mem_ready;
  assign youngest  = tail_q - PW'(1);

`ifdef LSU_SB_COALESCE_EN
  // A popping sole entry cannot absorb a store: it leaves this cycle.
  assign merge = push_ok && (count_q != '0) && (addr_q[youngest] == st_word) &&
                 !((count_q == CW'(1)) && pop);
`else
  assign merge = 1'b0;
`endif
  assign alloc = push_ok && !merge;

  // Pointer, occupancy and entry updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      // NOTE: the entry array is reset because the mem_* outputs read the head entry and must be 0 out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      misalign_q <= accept && st_bad;
      if (pop) head_q <= head_q + PW'(1);
      if (alloc) begin
        addr_q[tail_q] <= st_word;
        data_q[tail_q] <= st_wdata;
        mask_q[tail_q] <= st_mask;
        tail_q         <= tail_q + PW'(1);
      end
      if (merge) begin
        for (int j = 0; j < L; j++) begin
          if (st_mask[j]) data_q[youngest][8*j +: 8] <= st_wdata[8*j +: 8];
        end
        mask_q[youngest] <= mask_q[youngest] | st_mask;
      end
      count_q <= count_q + CW'(alloc) - CW'(pop);
    end
  end

  assign st_misalign = misalign_q;
  assign count       = count_q;
  assign mem_addr    = addr_q[head_q];
  assign mem_wdata   = data_q[head_q];
  assign mem_bmask   = mask_q[head_q];

  // Load lookup
  logic [OB-1:0]     ld_off;
  int                ld_bytes;
  logic              ld_bad;
  logic [L-1:0]      ld_need;
  logic [ADDR_W-1:0] ld_word;
  logic              fwd_found;
  logic [PW-1:0]     fwd_idx;
  logic              covered;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext;
  int                sign_pos;

  // Find the newest entry with a matching word address (oldest-to-newest scan, last match wins)
  always_comb begin
    fwd_found = 1'b0;
    fwd_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count_q) && (addr_q[head_q + PW'(k)] == ld_word)) begin
        fwd_found = 1'b1;
        fwd_idx   = head_q + PW'(k);
      end
    end
  end

  // Classify the match and extract/extend the forwarded lanes
  always_comb begin
    ld_off   = ld_addr[OB-1:0];
    ld_bytes = 1 << ld_size;
    ld_bad   = (ld_bytes > L) || ((int'(ld_off) & (ld_bytes - 1)) != 0);
    ld_word  = {ld_addr[ADDR_W-1:OB], {OB{1'b0}}};
    ld_need  = '0;
    for (int j = 0; j < L; j++) begin
      ld_need[j] = (j >= int'(ld_off)) && (j < int'(ld_off) + ld_bytes);
    end
    // Any shortfall in the newest match stalls the load; older entries may be stale for those lanes.
    covered    = ((mask_q[fwd_idx] & ld_need) == ld_need);
    ld_hit     = fwd_found && !ld_bad && covered;
    ld_partial = fwd_found && !ld_bad && !covered;
    shifted    = data_q[fwd_idx] >> {ld_off, 3'b000};
    sign_pos   = ld_bad ? DATA_W - 1 : 8 * ld_bytes - 1;
    ext        = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ext[b] = (b < 8 * ld_bytes) ? shifted[b] : (!ld_unsigned && shifted[sign_pos]);
    end
    ld_data = ld_hit ? ext : '0;
  end

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Self-checking bench for lsu_store_buffer (DATA_W=32, DEPTH=4): directed
// scenarios with literal expectations plus randomized traffic, all compared
// every cycle against a queue-based model of the buffer.
module tb_lsu_store_buffer;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        st_valid, st_ready, st_misalign;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic [31:0] ld_addr, ld_data;
  logic [1:0]  ld_size;
  logic        ld_unsigned, ld_hit, ld_partial;
  logic [2:0]  count;

  lsu_store_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_size(st_size), .st_data(st_data), .st_misalign(st_misalign),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bmask(mem_bmask),
    .ld_addr(ld_addr), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .ld_hit(ld_hit), .ld_partial(ld_partial), .ld_data(ld_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  ent_t q[$];
  bit   mis_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected load result from the buffered entries, newest first
  function automatic void model_load(output bit hit, output bit partial, output bit nomatch,
                                     output logic [31:0] data);
    int nb, off, idx;
    logic [31:0] word;
    logic [3:0]  need;
    nb = 1 << ld_size;
    off = int'(ld_addr % 4);
    word = ld_addr - off;
    idx = -1;
    need = 4'b0;
    hit = 0; partial = 0; nomatch = 1; data = 32'b0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (idx < 0 && q[i].addr == word) idx = i;
    if (idx >= 0) begin
      nomatch = 0;
      if (nb <= 4 && (off % nb) == 0) begin
        for (int b = 0; b < nb; b++) need[off + b] = 1'b1;
        if ((q[idx].mask & need) == need) begin
          hit = 1;
          for (int b = 0; b < nb; b++)
            data = data | ({24'b0, q[idx].data[8*(off+b) +: 8]} << (8 * b));
          if (!ld_unsigned && nb < 4 && data[8*nb-1])
            data = data | (32'hFFFF_FFFF << (8 * nb));
        end else begin
          partial = 1;
        end
      end
    end
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_update();
    int nb, off;
    bit pop, bad, merge;
    logic [31:0] word, d;
    logic [3:0]  m;
    ent_t e;
    pop = (q.size() != 0) && mem_ready;
    bad = 0; merge = 0;
    mis_exp = 0;
    if (st_valid && q.size() != DEPTH) begin
      nb = 1 << st_size;
      off = int'(st_addr % 4);
      bad = (nb > 4) || ((off % nb) != 0);
      if (bad) begin
        mis_exp = 1;
      end else begin
        word = st_addr - off;
        m = 4'b0;
        for (int b = 0; b < nb; b++) m[off + b] = 1'b1;
        d = st_data << (8 * off);
`ifdef LSU_SB_COALESCE_EN
        merge = (q.size() != 0) && (q[q.size()-1].addr == word) && !(q.size() == 1 && pop);
`endif
        if (merge) begin
          e = q[q.size()-1];
          for (int b = 0; b < 4; b++) if (m[b]) e.data[8*b +: 8] = d[8*b +: 8];
          e.mask = e.mask | m;
          q[q.size()-1] = e;
        end
        e.addr = word; e.data = d; e.mask = m;
      end
    end
    if (pop) void'(q.pop_front());
    if (st_valid && q.size() + (pop ? 1 : 0) != DEPTH && !bad && !merge) q.push_back(e);
  endtask

  task automatic compare_model();
    bit h, p, nm;
    logic [31:0] d;
    check("count", 64'(count), 64'(q.size()));
    check("st_ready", 64'(st_ready), 64'(q.size() != DEPTH));
    check("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    check("st_misalign", 64'(st_misalign), 64'(mis_exp));
    if (q.size() != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      check("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
      check("mem_bmask", 64'(mem_bmask), 64'(q[0].mask));
    end
    model_load(h, p, nm, d);
    check("ld_hit", 64'(ld_hit), 64'(h));
    check("ld_partial", 64'(ld_partial), 64'(p));
    if (h || nm) check("ld_data", 64'(ld_data), 64'(d));
  endtask

  // One clock: compare mid-cycle, advance model, return just after the edge
  task automatic step();
    @(negedge clk);
    compare_model();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_size = s; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    st_valid = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() != 0; i++) step();
    check("drain_empty", 64'(count), 64'd0);
    mem_ready = 1'b0;
  endtask

  logic [7:0] bytes_v [4];

  initial begin
    rst = 1'b0; st_valid = 0; st_addr = 0; st_size = 0; st_data = 0;
    mem_ready = 0; ld_addr = 32'h1000; ld_size = 0; ld_unsigned = 0;
    mis_exp = 0;
    #11;
    check("rst_count", 64'(count), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_bmask", 64'(mem_bmask), 64'd0);
    check("rst_misalign", 64'(st_misalign), 64'd0);
    check("rst_st_ready", 64'(st_ready), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Coalescing of four byte stores into one word
    bytes_v[0] = 8'hAA; bytes_v[1] = 8'hBB; bytes_v[2] = 8'hCC; bytes_v[3] = 8'hDD;
    for (int i = 0; i < 4; i++) store(32'h100 + i, 2'd0, {24'b0, bytes_v[i]});
`ifdef LSU_SB_COALESCE_EN
    check("coal_count", 64'(count), 64'd1);
    check("coal_wdata", 64'(mem_wdata), 64'hDDCCBBAA);
    check("coal_bmask", 64'(mem_bmask), 64'hF);
    check("coal_addr", 64'(mem_addr), 64'h100);
`else
    check("nocoal_count", 64'(count), 64'd4);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("nocoal_bmask", 64'(mem_bmask), 64'(1 << k));
      step();
    end
`endif
    drain();

    // Full buffer and drain order
    for (int i = 0; i < 4; i++) store(32'(4 * i), 2'd2, 32'hA000_0000 + i);
    check("full_st_ready", 64'(st_ready), 64'd0);
    st_valid = 1'b1; st_addr = 32'h10; st_size = 2'd2; st_data = 32'hA000_0010;
    mem_ready = 1'b1;
    step();
    check("full_pop_head", 64'(mem_addr), 64'h4);
    check("full_held_count", 64'(count), 64'd3);
    mem_ready = 1'b0;
    step();
    check("full_accept_count", 64'(count), 64'd4);
    st_valid = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_order", 64'(mem_addr), 64'(4 * (k + 1)));
      step();
    end
    drain();

    // Forwarding with sign/zero extension
    store(32'h200, 2'd2, 32'h12345678);
    ld_addr = 32'h203; ld_size = 2'd0; ld_unsigned = 1'b0; #1;
    check("fwd_byte_hit", 64'(ld_hit), 64'd1);
    check("fwd_byte_data", 64'(ld_data), 64'h12);
    store(32'h201, 2'd0, 32'hF0);
    ld_addr = 32'h200; ld_size = 2'd1; ld_unsigned = 1'b0; #1;
`ifdef LSU_SB_COALESCE_EN
    check("fwd_half_s", 64'(ld_data), 64'hFFFFF078);
    ld_unsigned = 1'b1; #1;
    check("fwd_half_u", 64'(ld_data), 64'h0000F078);
`else
    check("fwd_half_partial", 64'(ld_partial), 64'd1);
`endif
    step();
    drain();

    // Partial coverage
    store(32'h300, 2'd0, 32'hAA);
    ld_addr = 32'h300; ld_size = 2'd2; ld_unsigned = 1'b0; #1;
    check("part_hit", 64'(ld_hit), 64'd0);
    check("part_partial", 64'(ld_partial), 64'd1);
    ld_size = 2'd0; #1;
    check("part_byte_hit", 64'(ld_hit), 64'd1);
    check("part_byte_data", 64'(ld_data), 64'hFFFFFFAA);
    step();
    drain();

    // Misaligned stores are rejected with a one-cycle pulse
    store(32'h400, 2'd2, 32'hCAFE_F00D);
    store(32'h102, 2'd2, 32'h1111_1111);
    check("mis_word_pulse", 64'(st_misalign), 64'd1);
    check("mis_word_count", 64'(count), 64'd1);
    check("mis_word_head", 64'(mem_wdata), 64'hCAFE_F00D);
    step();
    check("mis_pulse_end", 64'(st_misalign), 64'd0);
    store(32'h101, 2'd1, 32'h2222);
    check("mis_half_pulse", 64'(st_misalign), 64'd1);
    check("mis_half_addr", 64'(mem_addr), 64'h400);
    step();
    drain();

    // Asynchronous reset mid-operation
    store(32'h600, 2'd2, 32'h1);
    store(32'h604, 2'd2, 32'h2);
    #2 rst = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_mem_valid", 64'(mem_valid), 64'd0);
    q.delete();
    mis_exp = 0;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    store(32'h500, 2'd2, 32'h5555_AAAA);
    check("arst_new_head", 64'(mem_addr), 64'h500);
    check("arst_new_count", 64'(count), 64'd1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      st_valid    = ($urandom_range(0, 9) < 6);
      st_size     = 2'($urandom_range(0, 3));
      st_addr     = 32'h100 + 32'($urandom_range(0, 15));
      st_data     = $urandom;
      mem_ready   = ($urandom_range(0, 9) < 4);
      ld_size     = 2'($urandom_range(0, 3));
      ld_addr     = 32'h100 + 32'($urandom_range(0, 15));
      ld_unsigned = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
